// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity type codes and default frame width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timer for the UART transmitter: edge counter, data-bit index and bit-boundary strobe.
module tx_bit_timer
    import uart_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [4:0]       prescale,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             bit_done
);

    logic [4:0] edge_cnt;

    // A prescale of 0 makes P-1 wrap to 31, giving the 32-cycle bit period.
    assign bit_done = (edge_cnt == prescale - 5'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, one stop bit; P clocks per bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [4:0]            prescale,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    tx_state_t             next_state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [4:0]            prescale_q;
    logic                  tx_d;
    logic                  accept;
    logic                  clear;
    logic                  bit_done;
    logic [CNT_W-1:0]      bit_cnt;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;
`else
    logic unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    tx_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .prescale(prescale_q),
        .bit_cnt (bit_cnt),
        .bit_done(bit_done)
    );

    assign clear = (next_state != state);
    assign busy  = (state != IDLE);

    // tx_d is the line value for the next cycle, so tx_out changes exactly on state/bit edges.
    always_comb begin
        next_state = state;
        tx_d       = tx_out;
        shift_d    = shift_q;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (data_valid) begin
                    accept     = 1'b1;
                    next_state = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    next_state = DATA;
                    tx_d       = shift_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            next_state = PARITY;
                            tx_d       = par_bit_q;
                        end else begin
                            next_state = STOP;
                            tx_d       = 1'b1;
                        end
`else
                        next_state = STOP;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    next_state = STOP;
                    tx_d       = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    next_state = IDLE;
                    tx_d       = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            shift_q    <= '0;
            prescale_q <= '0;
        end else begin
            state      <= next_state;
            tx_out     <= tx_d;
            shift_q    <= accept ? p_data : shift_d;
            prescale_q <= accept ? prescale : prescale_q;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= par_en;
            par_bit_q <= (par_typ == PAR_EVEN) ? ^p_data : ~^p_data;
        end
    end
`endif

endmodule
